arb_req_client: RTL and testbench
=================================

// Module: arb_req_client
// PURPOSE
//  Requester-side client for the team's 2-way req/gnt arbiter. Turns per-channel
//  burst commands (start + length) into req_0/req_1, holds each request until
//  the arbiter has granted it for the commanded number of cycles, then releases
//  and reports completion. Sits between two bus masters and the arbiter; gnt_x
//  comes straight from the arbiter's registered outputs.
// PARAMETERS
//  LEN_W    4   width of burst length inputs
//  TIMEOUT  15  wait cycles in REQ without grant before abort (REQ_TIMEOUT_EN only)
// PORTS
//  clock    in   1      rising-edge clock
//  reset    in   1      synchronous, active-high
//  start_0  in   1      channel 0 burst command, sampled when ch0 IDLE
//  len_0    in   LEN_W  channel 0 granted cycles required (0 treated as 1)
//  start_1  in   1      channel 1 burst command
//  len_1    in   LEN_W  channel 1 granted cycles required (0 treated as 1)
//  gnt_0    in   1      grant 0 from arbiter
//  gnt_1    in   1      grant 1 from arbiter
//  req_0    out  1      request 0 to arbiter
//  req_1    out  1      request 1 to arbiter
//  busy_0   out  1      channel 0 not IDLE
//  busy_1   out  1      channel 1 not IDLE
//  done_0   out  1      1-cycle pulse: channel 0 burst complete
//  done_1   out  1      1-cycle pulse: channel 1 burst complete
//  err_0    out  1      1-cycle pulse: channel 0 aborted on timeout
//  err_1    out  1      1-cycle pulse: channel 1 aborted on timeout
// BEHAVIOUR
//  - Reset: both channels IDLE; all outputs 0; counters 0. Overrides everything,
//    including start at the same edge and an in-progress burst.
//  - Channels independent, identical; all outputs registered. States per channel:
//    IDLE -> REQ -> BUSY -> IDLE.
//  - IDLE: start_x=1 at edge t -> REQ, rem <= max(len_x,1); req_x, busy_x =1 from t.
//    gnt_x ignored in IDLE (arbiter holds gnt one cycle after req drops).
//  - REQ: req_x=1. Edge with gnt_x=1 counts one granted cycle: rem==1 -> finish,
//    else rem-1 and -> BUSY. gnt_x=0 -> stay (wait counter +1, timeout build only).
//  - BUSY: req_x=1. Each edge with gnt_x=1 decrements rem; gnt_x=0 (preempted)
//    pauses count, req held. Edge where gnt_x=1 and rem==1 -> finish.
//  - Finish: at that edge req_x<=0, busy_x<=0, done_x<=1 for exactly 1 cycle,
//    state IDLE. start_x during done cycle is accepted (back-to-back bursts; req
//    drops for exactly 1 cycle between bursts).
//  - start_x while busy_x=1 ignored; len_x sampled only on accepted start.
//  - Total gnt_x-high edges counted per burst == max(len_x,1), exactly.
//  - gnt_x never gates req_y; simultaneous starts on both channels both go to REQ.
// CONFIGURATION
//  REQ_TIMEOUT_EN defined: per-channel wait counter (width clog2(TIMEOUT+1)),
//   cleared on entering REQ and on any gnt_x; if it reaches TIMEOUT while in REQ
//   with gnt_x=0 -> req_x<=0, busy_x<=0, err_x<=1 for 1 cycle, IDLE, no done_x.
//   BUSY is never timed out.
//  Not defined: no wait counter; REQ waits indefinitely; err_0/err_1 tied 0.
// TESTING
//  1 reset=1 for 2 cycles with start_0=start_1=1 -> all outputs 0 throughout and
//    1 cycle after; no REQ entered.
//  2 start_0, len_0=3, arbiter model grants 2 cycles after req -> req_0 high until
//    3rd gnt_0 edge, done_0 single pulse same cycle req_0 falls, trailing gnt_0
//    ignored; busy_0 low after.
//  3 start_0 len=2 and start_1 len=2 same cycle with real arbiter -> ch0 done
//    first, ch1 granted afterwards, each sees exactly 2 grant edges, gnt never
//    both high.
//  4 ch0 len=4, force gnt_0 low 3 cycles after 2nd grant -> req_0 held, count
//    paused, done_0 after 4th grant edge; start_0 pulses mid-burst ignored.
//  5 len_0=0 -> exactly 1 grant edge then done_0; start_0 in done cycle starts new
//    burst with req_0 low for 1 cycle; reset asserted mid-BUSY -> req_0=0, no done.
//  6 REQ_TIMEOUT_EN, TIMEOUT=4, gnt_1 held 0 -> err_1 pulse after 4 wait edges,
//    req_1 low, no done_1; without macro req_1 stays high 100 cycles, err_1=0.

Source files
------------

// File: rtl/arb_req_client.sv
// Requester-side client for the 2-way req/gnt arbiter: turns per-channel burst commands into held requests.
// Optional REQ_TIMEOUT_EN adds a per-channel wait counter that aborts a request never granted within TIMEOUT cycles.
module arb_req_client #(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_0,
    input  logic [LEN_W-1:0] len_0,
    input  logic             start_1,
    input  logic [LEN_W-1:0] len_1,
    input  logic             gnt_0,
    input  logic             gnt_1,
    output logic             req_0,
    output logic             req_1,
    output logic             busy_0,
    output logic             busy_1,
    output logic             done_0,
    output logic             done_1,
    output logic             err_0,
    output logic             err_1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_t;

    logic [1:0]       start_v;
    logic [1:0]       gnt_v;
    logic [1:0]       req_v;
    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       err_v;
    logic [LEN_W-1:0] len_v [2];

    assign start_v  = {start_1, start_0};
    assign gnt_v    = {gnt_1, gnt_0};
    assign len_v[0] = len_0;
    assign len_v[1] = len_1;

    assign req_0  = req_v[0];
    assign req_1  = req_v[1];
    assign busy_0 = busy_v[0];
    assign busy_1 = busy_v[1];
    assign done_0 = done_v[0];
    assign done_1 = done_v[1];
    assign err_0  = err_v[0];
    assign err_1  = err_v[1];

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t           state, state_next;
        logic [LEN_W-1:0] rem, rem_next;
        logic             req_q, req_next;
        logic             busy_q, busy_next;
        logic             done_q, done_next;
`ifdef REQ_TIMEOUT_EN
        localparam int WAIT_W = $clog2(TIMEOUT + 1);
        logic [WAIT_W-1:0] wait_cnt, wait_next;
        logic              err_q, err_next;
`endif

        always_ff @(posedge clock) begin
            if (reset) begin
                state  <= IDLE;
                rem    <= '0;
                req_q  <= 1'b0;
                busy_q <= 1'b0;
                done_q <= 1'b0;
`ifdef REQ_TIMEOUT_EN
                wait_cnt <= '0;
                err_q    <= 1'b0;
`endif
            end else begin
                state  <= state_next;
                rem    <= rem_next;
                req_q  <= req_next;
                busy_q <= busy_next;
                done_q <= done_next;
`ifdef REQ_TIMEOUT_EN
                wait_cnt <= wait_next;
                err_q    <= err_next;
`endif
            end
        end

        // Outputs are computed one cycle ahead so req/busy/done/err all leave registers.
        always_comb begin
            state_next = state;
            rem_next   = rem;
            req_next   = req_q;
            busy_next  = busy_q;
            done_next  = 1'b0;
`ifdef REQ_TIMEOUT_EN
            wait_next = wait_cnt;
            err_next  = 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start_v[c]) begin
                        state_next = REQ;
                        rem_next   = (len_v[c] == '0) ? LEN_W'(1) : len_v[c];
                        req_next   = 1'b1;
                        busy_next  = 1'b1;
`ifdef REQ_TIMEOUT_EN
                        wait_next = '0;
`endif
                    end
                end
                REQ, BUSY: begin
                    if (gnt_v[c]) begin
`ifdef REQ_TIMEOUT_EN
                        wait_next = '0;
`endif
                        if (rem == LEN_W'(1)) begin
                            state_next = IDLE;
                            req_next   = 1'b0;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = BUSY;
                            rem_next   = rem - 1'b1;
                        end
                    end
`ifdef REQ_TIMEOUT_EN
                    // Only a request that has never been granted can time out; a preempted burst waits forever.
                    else if (state == REQ) begin
                        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                            state_next = IDLE;
                            req_next   = 1'b0;
                            busy_next  = 1'b0;
                            err_next   = 1'b1;
                        end else begin
                            wait_next = wait_cnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                    busy_next  = 1'b0;
                end
            endcase
        end

        assign req_v[c]  = req_q;
        assign busy_v[c] = busy_q;
        assign done_v[c] = done_q;
`ifdef REQ_TIMEOUT_EN
        assign err_v[c] = err_q;
`else
        assign err_v[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client; outputs are packed as {req_1,req_0,busy_1,busy_0,done_1,done_0,err_1,err_0}.
// Build with REQ_TIMEOUT_EN defined to exercise the request timeout (TIMEOUT=4).
module tb_arb_req_client;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_0, start_1;
    logic [3:0] len_0, len_1;
    logic       gnt_0, gnt_1;
    logic       req_0, req_1, busy_0, busy_1, done_0, done_1, err_0, err_1;

    logic       use_arb;
    logic       g0_drv, g1_drv;
    logic [1:0] arb_gnt;
    logic [7:0] outs;

    int tests_run  = 0;
    int tests_fail = 0;
    int g0_edges   = 0;
    int g1_edges   = 0;
    int both_high  = 0;
    int snap0, snap1, snap_both;

    always #5 clock = ~clock;

    assign gnt_0 = use_arb ? arb_gnt[0] : g0_drv;
    assign gnt_1 = use_arb ? arb_gnt[1] : g1_drv;
    assign outs  = {req_1, req_0, busy_1, busy_0, done_1, done_0, err_1, err_0};

`ifdef REQ_TIMEOUT_EN
    arb_req_client #(.LEN_W(4), .TIMEOUT(4)) dut (
`else
    arb_req_client #(.LEN_W(4)) dut (
`endif
        .clock(clock), .reset(reset),
        .start_0(start_0), .len_0(len_0), .start_1(start_1), .len_1(len_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .req_0(req_0), .req_1(req_1), .busy_0(busy_0), .busy_1(busy_1),
        .done_0(done_0), .done_1(done_1), .err_0(err_0), .err_1(err_1)
    );

    // Registered arbiter model: keeps the current owner while it requests, so gnt trails req by one cycle.
    always @(posedge clock) begin
        if (reset)                    arb_gnt <= 2'b00;
        else if (arb_gnt[0] && req_0) arb_gnt <= 2'b01;
        else if (arb_gnt[1] && req_1) arb_gnt <= 2'b10;
        else if (req_0)               arb_gnt <= 2'b01;
        else if (req_1)               arb_gnt <= 2'b10;
        else                          arb_gnt <= 2'b00;
    end

    always @(posedge clock) begin
        if (gnt_0 && req_0)  g0_edges  <= g0_edges + 1;
        if (gnt_1 && req_1)  g1_edges  <= g1_edges + 1;
        if (gnt_0 && gnt_1)  both_high <= both_high + 1;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_fail++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed[7:0], expected[7:0]);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic s0, input logic [3:0] l0,
                                 input logic s1, input logic [3:0] l1,
                                 input logic g0, input logic g1);
        reset   = rst;
        start_0 = s0;
        len_0   = l0;
        start_1 = s1;
        len_1   = l1;
        g0_drv  = g0;
        g1_drv  = g1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        use_arb = 1'b0;
        reset = 1'b1; start_0 = 1'b0; start_1 = 1'b0; len_0 = '0; len_1 = '0;
        g0_drv = 1'b0; g1_drv = 1'b0;
        #1;

        // Reset wins over simultaneous starts
        applyStimulus(1, 1, 4'd3, 1, 4'd3, 0, 0); checkOutput("rst_c1", outs, 8'b0000_0000);
        applyStimulus(1, 1, 4'd3, 1, 4'd3, 0, 0); checkOutput("rst_c2", outs, 8'b0000_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("rst_after", outs, 8'b0000_0000);

        // len 3 burst with grants two cycles after req, then a trailing grant
        applyStimulus(0, 1, 4'd3, 0, 4'd0, 0, 0); checkOutput("b3_start", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("b3_wait", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("b3_g1", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("b3_g2", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("b3_done", outs, 8'b0000_0100);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("b3_trail", outs, 8'b0000_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("b3_idle", outs, 8'b0000_0000);

        // Both channels start together behind the arbiter model
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_rst", outs, 8'b0000_0000);
        use_arb   = 1'b1;
        snap0     = g0_edges;
        snap1     = g1_edges;
        snap_both = both_high;
        applyStimulus(0, 1, 4'd2, 1, 4'd2, 0, 0); checkOutput("arb_e1", outs, 8'b1111_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e2", outs, 8'b1111_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e3", outs, 8'b1111_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e4", outs, 8'b1010_0100);
`ifdef REQ_TIMEOUT_EN
        // ch1 has now waited 4 ungranted edges and aborts
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e5", outs, 8'b0000_0010);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e6", outs, 8'b0000_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e7", outs, 8'b0000_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e8", outs, 8'b0000_0000);
        checkOutput("arb_g1_edges", g1_edges - snap1, 0);
`else
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e5", outs, 8'b1010_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e6", outs, 8'b1010_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e7", outs, 8'b0000_1000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("arb_e8", outs, 8'b0000_0000);
        checkOutput("arb_g1_edges", g1_edges - snap1, 2);
`endif
        checkOutput("arb_g0_edges", g0_edges - snap0, 2);
        checkOutput("arb_no_overlap", both_high - snap_both, 0);
        use_arb = 1'b0;

        // Preemption pauses the count; start pulses mid-burst are ignored
        applyStimulus(0, 1, 4'd4, 0, 4'd0, 0, 0); checkOutput("pre_start", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("pre_g1", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("pre_g2", outs, 8'b0101_0000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 4'd1, 0, 4'd0, 0, 0); checkOutput("pre_hold", outs, 8'b0101_0000);
        end
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("pre_g3", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("pre_done", outs, 8'b0000_0100);

        // len 0 acts as 1, back-to-back restart, reset mid-burst
        applyStimulus(0, 1, 4'd0, 0, 4'd0, 0, 0); checkOutput("z_start", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("z_done", outs, 8'b0000_0100);
        applyStimulus(0, 1, 4'd2, 0, 4'd0, 1, 0); checkOutput("z_restart", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("z_wait", outs, 8'b0101_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("z_busy", outs, 8'b0101_0000);
        applyStimulus(1, 0, 4'd0, 0, 4'd0, 1, 0); checkOutput("z_reset", outs, 8'b0000_0000);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("z_no_done", outs, 8'b0000_0000);

        // Channel 1 never granted
        applyStimulus(0, 0, 4'd0, 1, 4'd1, 0, 0); checkOutput("to_start", outs, 8'b1010_0000);
`ifdef REQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("to_wait", outs, 8'b1010_0000);
        end
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("to_err", outs, 8'b0000_0010);
        applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("to_after", outs, 8'b0000_0000);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(0, 0, 4'd0, 0, 4'd0, 0, 0); checkOutput("to_hold", outs, 8'b1010_0000);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
